// File: rtl/rom_reader_pkg.sv
// Shared definitions for the ROM stream reader: FSM states, parameter defaults
// and the RD_LAT/FIFO_D legality rule.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int RD_LAT_DEF = 1;
  localparam int FIFO_D_DEF = 4;
  localparam int LEN_W_DEF  = 16;

  // The buffer must hold every word that can be in flight plus one being consumed.
  function automatic bit params_legal(input int rd_lat, input int fifo_d);
    return (rd_lat >= 1) && (rd_lat <= 2) && (fifo_d >= rd_lat + 1);
  endfunction

endpackage

// File: rtl/rom_rd_fifo.sv
// Synchronous show-ahead FIFO holding {last, data} words for the stream reader;
// dout always shows the oldest entry, count reports occupancy.
module rom_rd_fifo #(
  parameter int W  = 33,
  parameter int D  = 4,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap at D so non-power-of-two depths also work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/rom_stream_reader.sv
// Streams LEN consecutive ROM words from BASE_ADDR onto a valid/ready port.
// Optional running checksum output enabled by defining ROM_CHECKSUM_EN.
module rom_stream_reader
  import rom_reader_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int FIFO_D = FIFO_D_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_we,
  output logic [31:0]      mem_din,
  input  logic [31:0]      mem_dout,
  output logic [31:0]      m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [31:0]      csum
`endif
);

  localparam int CW = $clog2(FIFO_D + 1);

  if (!params_legal(RD_LAT, FIFO_D)) begin : g_param_check
    $error("rom_stream_reader: illegal RD_LAT/FIFO_D combination");
  end

  rd_state_t        state, state_nx;
  logic [31:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [RD_LAT:0]  pipe_vld;
  logic [RD_LAT:0]  pipe_last;
  logic             issue, done_nx, push, pop;
  logic [32:0]      fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  int               occ;

  // Buffered words plus reads still travelling through the ROM.
  always_comb begin
    occ = int'(fifo_count);
    for (int i = 0; i <= RD_LAT; i++) occ = occ + int'(pipe_vld[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) state_nx = ST_RUN;
          else           done_nx  = 1'b1;
        end
      end
      ST_RUN: begin
        if (remaining == '0) begin
          state_nx = ST_DRAIN;
        end else if (occ < FIFO_D) begin
          issue = 1'b1;
          if (remaining == LEN_W'(1)) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last-tagged word is the final one issued, so nothing is in flight behind it.
        if (pop && fifo_head[32]) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      mem_addr  <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        addr      <= base_addr;
        remaining <= len;
      end else if (issue) begin
        mem_addr  <= addr;
        addr      <= addr + 32'd1;
        remaining <= remaining - LEN_W'(1);
      end
      pipe_vld  <= {pipe_vld[RD_LAT-1:0], issue};
      pipe_last <= {pipe_last[RD_LAT-1:0], issue && (remaining == LEN_W'(1))};
    end
  end

  assign push = pipe_vld[RD_LAT];
  assign pop  = m_valid & m_ready;

  rom_rd_fifo #(.W(33), .D(FIFO_D), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({pipe_last[RD_LAT], mem_dout}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? fifo_head[31:0] : 32'd0;
  assign m_last  = m_valid & fifo_head[32];
  assign busy    = (state != ST_IDLE);
  assign mem_we  = 4'd0;
  assign mem_din = 32'd0;

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        csum <= '0;
    else if (state == ST_IDLE && start) csum <= '0;
    else if (pop)                      csum <= csum + m_data;
  end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: expected words are queued at command
// launch and a negedge monitor pops/compares on every stream handshake.
module tb_rom_stream_reader;

  localparam int RD_LAT = 1;
  localparam int LEN_W  = 16;
  localparam int FIFO_D = 4;

  logic             clk, rst_n, start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len;
  logic             busy, done;
  logic [31:0]      mem_addr, mem_din, mem_dout, m_data;
  logic [3:0]       mem_we;
  logic             m_valid, m_ready, m_last;
`ifdef ROM_CHECKSUM_EN
  logic [31:0]      csum;
`endif

  rom_stream_reader #(.RD_LAT(RD_LAT), .LEN_W(LEN_W), .FIFO_D(FIFO_D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
`ifdef ROM_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: mem[i] = A500_0000 + i for every word address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA500_0000 + a;
  endfunction

  logic [31:0] rom_pipe [RD_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_word(mem_addr);
    for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign mem_dout = rom_pipe[RD_LAT-1];

  int          n_cmp = 0, n_bad = 0;
  int          cycle = 0;
  logic [32:0] exp_q [$];
  int          rcv_count = 0, done_count = 0, cmd_done0 = 0;
  int          first_hs = -1, last_hs = -1;
  logic [31:0] cmd_sum;
  int          ready_mode = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // m_ready pattern: 0 = held high, 1 = toggling, 2 = random, 3 = held low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid_hold", 64'(m_valid), 64'd1);
        checkOutput("stall_data_hold", 64'(m_data), 64'(prev_data));
      end
      if (done) done_count++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word (cycle %0d)", m_data, cycle);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          checkOutput("m_data", 64'(m_data), 64'(e[31:0]));
          checkOutput("m_last", 64'(m_last), 64'(e[32]));
          rcv_count++;
          if (first_hs < 0) first_hs = cycle;
          last_hs = cycle;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic launchCmd(input logic [31:0] b, input int n);
    cmd_done0 = done_count;
    rcv_count = 0;
    first_hs  = -1;
    cmd_sum   = 32'd0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = rom_word(b + 32'(i));
      exp_q.push_back({(i == n - 1), w});
      cmd_sum = cmd_sum + w;
    end
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    len       = LEN_W'(n);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic finishCmd(input int n);
    int c;
    @(negedge clk);
    if (n != 0) checkOutput("busy_after_start", 64'(busy), 64'd1);
    else begin
      checkOutput("len0_done_next", 64'(done), 64'd1);
      checkOutput("len0_busy", 64'(busy), 64'd0);
      checkOutput("len0_valid", 64'(m_valid), 64'd0);
    end
`ifdef ROM_CHECKSUM_EN
    if (n > 1) checkOutput("csum_cleared", 64'(csum), 64'd0);
`endif
    c = 0;
    while (!done && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (!done) checkOutput("done_timeout", 64'(c), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("done_once", 64'(done_count - cmd_done0), 64'd1);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);
`ifdef ROM_CHECKSUM_EN
    checkOutput("csum_total", 64'(csum), 64'(cmd_sum));
`endif
  endtask

  task automatic applyStimulus(input logic [31:0] b, input int n, input int mode);
    ready_mode = mode;
    launchCmd(b, n);
    finishCmd(n);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "_m_last"}, 64'(m_last), 64'd0);
    checkOutput({tag, "_m_data"}, 64'(m_data), 64'd0);
    checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
`ifdef ROM_CHECKSUM_EN
    checkOutput({tag, "_csum"}, 64'(csum), 64'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] saved_addr;
    int c;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    checkOutput("mem_we_zero", 64'(mem_we), 64'd0);
    checkOutput("mem_din_zero", 64'(mem_din), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] burst of 4 with ready high");
    applyStimulus(32'h10, 4, 0);
    checkOutput("burst_span", 64'(last_hs - first_hs), 64'd3);

    $display("[TB] burst of 4 with ready toggling");
    applyStimulus(32'h10, 4, 1);

    $display("[TB] backpressure, len 10");
    ready_mode = 3;
    launchCmd(32'h40, 10);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h99; len = LEN_W'(3);
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("stall_reads_capped", 64'(mem_addr), 64'(32'h40 + FIFO_D - 1));
    checkOutput("stall_no_words", 64'(rcv_count), 64'd0);
    ready_mode = 0;
    finishCmd(10);

    $display("[TB] zero-length command");
    saved_addr = mem_addr;
    applyStimulus(32'h80, 0, 0);
    checkOutput("len0_mem_addr", 64'(mem_addr), 64'(saved_addr));

    $display("[TB] reset mid-command");
    ready_mode = 0;
    launchCmd(32'h20, 10);
    c = 0;
    while (rcv_count < 3 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput("words_before_reset", 64'(rcv_count >= 3), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkResetState("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(32'h30, 2, 0);

    $display("[TB] checksum burst base 0 len 3");
    applyStimulus(32'h0, 3, 0);
`ifdef ROM_CHECKSUM_EN
    checkOutput("csum_literal", 64'(csum), 64'h0000_0000_EF00_0003);
`endif

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFFE, 4, 2);

    $display("[TB] randomized commands");
    for (int k = 0; k < 12; k++) begin
      logic [31:0] b;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else                            b = $urandom;
      applyStimulus(b, int'($urandom_range(1, 12)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
